// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Holds FSM states, the NOP encoding and the queue entry layout.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INST = 32'b0;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {PC+4, instruction} entries.
// Flush empties the queue in one cycle; the head is read from registers.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  fetch_entry_t  i_data,
   output fetch_entry_t  o_head,
   output logic [CW-1:0] o_count,
   output logic          o_empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (i_push)
            r_wr <= r_wr + 1'b1;
         if (i_pop)
            r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush)
         r_mem[r_wr] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one outstanding imem request at a time
// and presents queued {PC+4, instruction} pairs to the IF/ID register.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          PC_STEP     = 4,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pcOut,
   output logic [31:0] instOut,
   output logic        validOut
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [31:0] STEP = 32'(PC_STEP);

   fetch_state_e  r_state;
   fetch_state_e  w_state_n;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_n;
   logic [31:0]   r_addr;
   logic [31:0]   w_addr_n;
   logic [31:0]   w_addr_inc;
   logic          w_push;
   logic          w_pop;
   logic          w_flush;
   logic          w_room;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_n;
   fetch_entry_t  w_head;
   fetch_entry_t  w_entry;

   assign w_addr_inc = r_addr + STEP;
   assign w_flush    = branch_taken;
   assign w_push     = (r_state == WAIT) && imem_ready && !branch_taken;
   assign w_pop      = !w_empty && !freeze && !branch_taken;
   assign w_count_n  = w_flush ? '0
                     : w_count + CW'(w_push) - CW'(w_pop);
   assign w_room     = (w_count_n < CW'(QUEUE_DEPTH));
   assign w_entry    = '{pc_plus4: w_addr_inc, inst: imem_rdata};

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_entry),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_addr  <= w_addr_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_addr_n  = r_addr;
      unique case (r_state)
         IDLE: begin
            if (branch_taken) begin
               w_state_n = WAIT;
               w_pc_n    = branch_addr;
               w_addr_n  = branch_addr;
            end else if (w_room) begin
               w_state_n = WAIT;
               w_addr_n  = r_pc;
            end
         end
         WAIT: begin
            if (branch_taken) begin
               w_pc_n = branch_addr;
               // A response arriving now belongs to the old path.
               if (imem_ready)
                  w_addr_n = branch_addr;
               else
                  w_state_n = DROP;
            end else if (imem_ready) begin
               w_pc_n = w_addr_inc;
               if (w_room)
                  w_addr_n = w_addr_inc;
               else
                  w_state_n = IDLE;
            end
         end
         DROP: begin
            if (branch_taken) begin
               w_pc_n = branch_addr;
            end else if (imem_ready) begin
               w_state_n = WAIT;
               w_addr_n  = r_pc;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (r_state != IDLE);
      imem_addr = r_addr;
      validOut  = !w_empty;
      pcOut     = w_empty ? 32'b0 : w_head.pc_plus4;
      instOut   = w_empty ? NOP_INST : w_head.inst;
   end

endmodule
